// File: rtl/sign_pkg.sv
// Shared sign-code definitions: finger patterns, FSM encodings and code helpers.
// Used by both the pattern generator and the sign decoder so the two agree on every code.
package sign_pkg;

  localparam int SIGN_W           = 4;
  localparam int FINGER_W         = 5;
  localparam int SIGN_QUEUE_DEPTH = 4;

  localparam logic [SIGN_W-1:0] SIGN_MAX = 4'd9;

  // Bit order is {pinky, ring, middle, index, thumb}; 1 = finger raised.
  localparam logic [FINGER_W-1:0] PAT_0    = 5'b00000;
  localparam logic [FINGER_W-1:0] PAT_1    = 5'b00010;
  localparam logic [FINGER_W-1:0] PAT_2    = 5'b00110;
  localparam logic [FINGER_W-1:0] PAT_3    = 5'b01110;
  localparam logic [FINGER_W-1:0] PAT_4    = 5'b11110;
  localparam logic [FINGER_W-1:0] PAT_5    = 5'b11111;
  localparam logic [FINGER_W-1:0] PAT_6    = 5'b10001;
  localparam logic [FINGER_W-1:0] PAT_7    = 5'b00011;
  localparam logic [FINGER_W-1:0] PAT_8    = 5'b00111;
  localparam logic [FINGER_W-1:0] PAT_9    = 5'b01111;
  localparam logic [FINGER_W-1:0] PAT_REST = 5'b00000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  function automatic logic sign_is_valid(input logic [SIGN_W-1:0] code);
    return code <= SIGN_MAX;
  endfunction

  function automatic logic [FINGER_W-1:0] sign_pattern(input logic [SIGN_W-1:0] code);
    case (code)
      4'd0:    return PAT_0;
      4'd1:    return PAT_1;
      4'd2:    return PAT_2;
      4'd3:    return PAT_3;
      4'd4:    return PAT_4;
      4'd5:    return PAT_5;
      4'd6:    return PAT_6;
      4'd7:    return PAT_7;
      4'd8:    return PAT_8;
      4'd9:    return PAT_9;
      default: return PAT_REST;
    endcase
  endfunction

endpackage

// File: rtl/sign_queue.sv
// Small synchronous FIFO holding sign codes ahead of the pattern FSM.
// Push while full is accepted only when a pop happens on the same edge.
module sign_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the pointers and count are what define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sign_pattern_generator.sv
// Drives five finger lines with the pattern of an accepted sign code, then a rest gap.
// Define SIGN_QUEUE_EN to place a 4-entry code FIFO in front of the FSM.
module sign_pattern_generator
  import sign_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIGN_W-1:0] sign_in,
  input  logic              sign_valid,
  output logic              sign_ready,
  output logic              thumb_status,
  output logic              index_status,
  output logic              middle_status,
  output logic              ring_status,
  output logic              pinky_status,
  output logic              busy,
  output logic              sign_done,
  output logic              invalid_sign
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("HOLD_CYCLES must lie in 1..2**CNT_W-1");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > (1 << CNT_W)) begin : g_bad_gap
    $error("GAP_CYCLES must lie in 0..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [FINGER_W-1:0] r_fingers;
  logic                r_sign_done;
  logic                r_invalid;

  logic                w_start;
  logic                w_reject;
  logic [SIGN_W-1:0]   w_code;

`ifdef SIGN_QUEUE_EN
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [SIGN_W-1:0] w_q_data;

  sign_queue #(
    .WIDTH (SIGN_W),
    .DEPTH (SIGN_QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (sign_in),
    .i_pop   (w_start),
    .o_data  (w_q_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Invalid codes never enter the FIFO; they only raise the invalid pulse.
  assign sign_ready = !w_full;
  assign w_push     = sign_valid && !w_full && sign_is_valid(sign_in);
  assign w_reject   = sign_valid && !w_full && !sign_is_valid(sign_in);
  assign w_start    = (r_state == S_IDLE) && !w_empty;
  assign w_code     = w_q_data;
  assign busy       = (r_state != S_IDLE) || !w_empty;
`else
  assign sign_ready = (r_state == S_IDLE);
  assign w_start    = (r_state == S_IDLE) && sign_valid && sign_is_valid(sign_in);
  assign w_reject   = (r_state == S_IDLE) && sign_valid && !sign_is_valid(sign_in);
  assign w_code     = sign_in;
  assign busy       = (r_state != S_IDLE);
`endif

  // sign_done is set on the edge that enters the final HOLD (no gap) or final GAP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fingers   <= PAT_REST;
      r_sign_done <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      r_sign_done <= 1'b0;
      r_invalid   <= w_reject;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_fingers   <= sign_pattern(w_code);
            r_cnt       <= HOLD_LOAD;
            r_state     <= S_HOLD;
            r_sign_done <= (HOLD_CYCLES == 1) && (GAP_CYCLES == 0);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            if (GAP_CYCLES > 0) begin
              r_fingers   <= PAT_REST;
              r_cnt       <= GAP_LOAD;
              r_state     <= S_GAP;
              r_sign_done <= (GAP_CYCLES == 1);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt       <= r_cnt - CNT_ONE;
            r_sign_done <= (GAP_CYCLES == 0) && (r_cnt == CNT_ONE);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt       <= r_cnt - CNT_ONE;
            r_sign_done <= (r_cnt == CNT_ONE);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {pinky_status, ring_status, middle_status, index_status, thumb_status} = r_fingers;
  assign sign_done    = r_sign_done;
  assign invalid_sign = r_invalid;

endmodule

// File: tb/tb_sign_pattern_generator.sv
// Scoreboard bench: one DUT at default timing, one with no rest gap.
// Expected patterns are queued at each handshake and compared as the DUT emits them.
module tb_sign_pattern_generator;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int TO   = 300;

  typedef struct packed {
    logic [4:0] pat;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sign_in0, sign_in1;
  logic       sign_valid0, sign_valid1;
  logic       ready0, thumb0, index0, middle0, ring0, pinky0, busy0, done0, inv0;
  logic       ready1, thumb1, index1, middle1, ring1, pinky1, busy1, done1, inv1;
  logic [7:0] obs0, obs1;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   seq_codes [8];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sign_pattern_generator dut (
    .clk (clk), .rst (rst), .sign_in (sign_in0), .sign_valid (sign_valid0),
    .sign_ready (ready0), .thumb_status (thumb0), .index_status (index0),
    .middle_status (middle0), .ring_status (ring0), .pinky_status (pinky0),
    .busy (busy0), .sign_done (done0), .invalid_sign (inv0)
  );

  sign_pattern_generator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .CNT_W(8)) dut_ng (
    .clk (clk), .rst (rst), .sign_in (sign_in1), .sign_valid (sign_valid1),
    .sign_ready (ready1), .thumb_status (thumb1), .index_status (index1),
    .middle_status (middle1), .ring_status (ring1), .pinky_status (pinky1),
    .busy (busy1), .sign_done (done1), .invalid_sign (inv1)
  );

  assign obs0 = {pinky0, ring0, middle0, index0, thumb0, busy0, done0, inv0};
  assign obs1 = {pinky1, ring1, middle1, index1, thumb1, busy1, done1, inv1};

  function automatic logic [4:0] model_pat(input int code);
    case (code)
      0: return 5'b00000;
      1: return 5'b00010;
      2: return 5'b00110;
      3: return 5'b01110;
      4: return 5'b11110;
      5: return 5'b11111;
      6: return 5'b10001;
      7: return 5'b00011;
      8: return 5'b00111;
      9: return 5'b01111;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [7:0] obs(input int which);
    return (which == 0) ? obs0 : obs1;
  endfunction

  function automatic logic rdy(input int which);
    return (which == 0) ? ready0 : ready1;
  endfunction

  task automatic set_in(input int which, input logic v, input logic [3:0] c);
    if (which == 0) begin
      sign_valid0 = v;
      sign_in0    = c;
    end else begin
      sign_valid1 = v;
      sign_in1    = c;
    end
  endtask

  // Presents seq_codes[0..n-1] with valid held; queues an expectation at every handshake.
  task automatic drive_seq(input int which, input int n, input int acc_step, input bit check_full);
    int   i        = 0;
    int   guard    = 0;
    int   prev_acc = -1;
    exp_t e;
    while (i < n && guard < TO) begin
      @(negedge clk);
      set_in(which, 1'b1, seq_codes[i][3:0]);
      if (rdy(which) === 1'b1) begin
        if (acc_step > 0 && prev_acc >= 0) begin
          checks++;
          if (cyc - prev_acc != acc_step) begin
            errors++;
            $display("FAIL accept_spacing dut%0d code%0d: got %0d cycles, expected %0d",
                     which, seq_codes[i], cyc - prev_acc, acc_step);
          end
        end
        prev_acc = cyc;
        if (seq_codes[i] <= 9) begin
          e.pat = model_pat(seq_codes[i]);
          e.acc = cyc;
          if (which == 0) exp_q0.push_back(e);
          else            exp_q1.push_back(e);
        end
        i++;
      end
      guard++;
    end
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got %0d accepted, expected %0d", which, i, n);
    end
    @(negedge clk);
    set_in(which, 1'b0, 4'd0);
    if (check_full) begin
      checks++;
      if (rdy(which) !== 1'b0) begin
        errors++;
        $display("FAIL ready_when_full dut%0d: got %b, expected 0", which, rdy(which));
      end
    end
  endtask

  // Pops each expectation, aligns to its predicted first pattern cycle and checks the whole window.
  task automatic check_stream(input int which, input int n, input int gap);
    int         last_done = -100;
    int         start;
    int         guard;
    exp_t       e;
    logic [7:0] exp_v;
    logic [7:0] got;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (((which == 0) ? exp_q0.size() : exp_q1.size()) == 0 && guard < TO) begin
        @(negedge clk);
        guard++;
      end
      if (((which == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_timeout dut%0d: got no accepted sign, expected sign %0d", which, k);
        return;
      end
      e = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
`ifdef SIGN_QUEUE_EN
      start = (e.acc + 2 > last_done + 2) ? e.acc + 2 : last_done + 2;
`else
      start = e.acc + 1;
`endif
      guard = 0;
      while (cyc < start && guard < TO) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (cyc != start) begin
        errors++;
        $display("FAIL start_align dut%0d: got cycle %0d, expected %0d", which, cyc, start);
      end
      for (int i = 0; i < HOLD; i++) begin
        if (i > 0) @(negedge clk);
        exp_v = {e.pat, 1'b1, (gap == 0 && i == HOLD - 1), 1'b0};
        got   = obs(which);
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL hold dut%0d sign%0d cyc%0d: got %b, expected %b", which, k, i, got, exp_v);
        end
`ifndef SIGN_QUEUE_EN
        checks++;
        if (rdy(which) !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_hold dut%0d: got %b, expected 0", which, rdy(which));
        end
`endif
      end
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        exp_v = {5'b00000, 1'b1, (j == gap - 1), 1'b0};
        got   = obs(which);
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL gap dut%0d sign%0d cyc%0d: got %b, expected %b", which, k, j, got, exp_v);
        end
      end
      last_done = cyc;
      @(negedge clk);
      got = obs(which);
      exp_v = {((gap == 0) ? e.pat : 5'b00000), 3'b000};
      checks++;
`ifdef SIGN_QUEUE_EN
      if ({got[7:3], got[1:0]} !== {exp_v[7:3], exp_v[1:0]}) begin
`else
      if (got !== exp_v || rdy(which) !== 1'b1) begin
`endif
        errors++;
        $display("FAIL after_sign dut%0d sign%0d: got %b ready %b, expected %b ready 1",
                 which, k, got, rdy(which), exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(0, 1'b1, 4'd5);
    set_in(1, 1'b1, 4'd5);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs0 !== 8'h00 || obs1 !== 8'h00 || ready0 !== 1'b1 || ready1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_values: got %b/%b ready %b/%b, expected 00000000 ready 1",
                 obs0, obs1, ready0, ready1);
      end
    end
    set_in(0, 1'b0, 4'd0);
    set_in(1, 1'b0, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0 !== 8'h00 || obs1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_accept: got %b/%b, expected 00000000", obs0, obs1);
    end
  endtask

  task automatic test_single_sign();
    seq_codes[0] = 3;
    fork
      drive_seq(0, 1, 0, 1'b0);
      check_stream(0, 1, GAP);
    join
  endtask

  task automatic test_no_gap();
    seq_codes[0] = 7;
    fork
      drive_seq(1, 1, 0, 1'b0);
      check_stream(1, 1, 0);
    join
  endtask

  task automatic test_invalid(input logic [4:0] kept);
    @(negedge clk);
    set_in(1, 1'b1, 4'd12);
    @(negedge clk);
    set_in(1, 1'b0, 4'd0);
    checks++;
    if (obs1 !== {kept, 3'b001} || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL invalid_pulse: got %b ready %b, expected %b ready 1", obs1, ready1, {kept, 3'b001});
    end
    @(negedge clk);
    checks++;
    if (obs1 !== {kept, 3'b000} || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL invalid_one_cycle: got %b ready %b, expected %b ready 1", obs1, ready1, {kept, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    seq_codes[0] = 1;
    seq_codes[1] = 2;
    seq_codes[2] = 4;
    seq_codes[3] = 5;
    fork
`ifdef SIGN_QUEUE_EN
      drive_seq(0, 4, 1, 1'b0);
`else
      drive_seq(0, 4, HOLD + GAP + 1, 1'b0);
`endif
      check_stream(0, 4, GAP);
    join
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    @(negedge clk);
    set_in(0, 1'b1, 4'd9);
    @(negedge clk);
    set_in(0, 1'b0, 4'd0);
    while (obs0[7:3] !== 5'b01111 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (obs0[7:3] !== 5'b01111) begin
      errors++;
      $display("FAIL mid_reset_load: got %b, expected fingers 01111", obs0[7:3]);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs0 !== 8'h00 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %b ready %b, expected 00000000 ready 1", obs0, ready0);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs0 !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold: got %b, expected 00000000", obs0);
      end
    end
    rst = 1'b1;
    seq_codes[0] = 6;
    fork
      drive_seq(0, 1, 0, 1'b0);
      check_stream(0, 1, GAP);
    join
  endtask

`ifdef SIGN_QUEUE_EN
  task automatic test_queue();
    seq_codes[0] = 7;
    seq_codes[1] = 8;
    seq_codes[2] = 0;
    seq_codes[3] = 1;
    seq_codes[4] = 2;
    fork
      drive_seq(1, 5, 1, 1'b1);
      check_stream(1, 5, 0);
    join
  endtask
`endif

  initial begin
    rst         = 1'b0;
    sign_valid0 = 1'b0;
    sign_valid1 = 1'b0;
    sign_in0    = 4'd0;
    sign_in1    = 4'd0;
    test_reset();
    test_single_sign();
    test_no_gap();
    test_invalid(model_pat(7));
    test_back_to_back();
    test_mid_reset();
`ifdef SIGN_QUEUE_EN
    test_queue();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
